// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB first,
// WIDTH cycles per operation behind a start/busy/done handshake.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic             bit_s;
    logic             carry_nxt_s;
    logic             last_s;

    // Full-adder cell on the current LSBs and end-of-operand detect
    always_comb begin
        bit_s       = a_r[0] ^ b_r[0] ^ carry_r;
        carry_nxt_s = (a_r[0] & b_r[0]) | (a_r[0] & carry_r) | (b_r[0] & carry_r);
        last_s      = (cnt_r == CW'(WIDTH - 1));
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand shifters, carry, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            res_r    <= '0;
            cnt_r    <= '0;
            carry_r  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            busy <= (state_nxt_s == RUN);
            done <= (state_nxt_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        // subtraction is a + ~b + 1
                        b_r     <= sub ? ~b : b;
                        carry_r <= sub ? 1'b1 : cin;
                        cnt_r   <= '0;
                    end
                end
                RUN: begin
                    res_r   <= {bit_s, res_r[WIDTH-1:1]};
                    a_r     <= {1'b0, a_r[WIDTH-1:1]};
                    b_r     <= {1'b0, b_r[WIDTH-1:1]};
                    carry_r <= carry_nxt_s;
                    cnt_r   <= cnt_r + CW'(1);
                    if (last_s) begin
                        sum      <= {bit_s, res_r[WIDTH-1:1]};
                        cout     <= carry_nxt_s;
                        // carry into MSB differs from carry out of MSB
                        overflow <= carry_r ^ carry_nxt_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor built around a single full-adder cell and a carry flip-flop. It accepts two WIDTH-bit operands through a start/busy/done handshake and processes one bit per clock, LSB first. After WIDTH cycles it presents the sum, carry-out and signed overflow. It is the area-reduced, multi-cycle successor to the combinational full adder, and adds subtract mode, carry-in and overflow detection.

## Interface

- WIDTH, 8, operand and result width in bits; legal range 2 to 64.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = a + b + cin; 1 = a − b (cin ignored); sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- cin  input  1  carry-in for add; sampled with start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result; holds until the next accepted start.
- cout  output  1  carry-out. In subtract mode, 1 means no borrow.
- overflow  output  1  two's-complement overflow of the operation.

## Operation

- One clock and one reset: reset is synchronous and active-high.
- FSM states are IDLE, RUN and DONE. Reset forces IDLE.
- **Reset values:** busy=0, done=0, sum=0, cout=0, overflow=0. Internal shift registers, bit counter and carry flop are also cleared to 0.
- **IDLE:**
  - If start=1 at a clock edge, latch a into shift register A.
  - Latch b, or ~b when sub=1, into shift register B.
  - Load the carry flop with cin, or with 1 when sub=1.
  - Clear the counter and go to RUN.
  - If start=0, stay in IDLE. All outputs hold their values.
- **RUN:** on each edge:
  - s = A[0]^B[0]^c.
  - c_next = majority(A[0],B[0],c).
  - Shift s into the MSB of the result register (right shift).
  - Shift A and B right by 1.
  - Increment the counter.
  - On the bit with counter = WIDTH−1:
    - Capture the carry into the MSB as c.
    - cout = c_next.
    - overflow = c ^ c_next.
    - Go to DONE.
- **DONE:** done=1 for exactly one cycle, then unconditionally return to IDLE.
- start is ignored in RUN and DONE. No queuing: a start presented in DONE is lost, and the next request must be presented in IDLE.
- The sum, cout and overflow outputs are updated only when the result register completes, on the edge entering DONE. Their previous values hold throughout RUN; no partial results are visible.
- Arithmetic is modulo 2^WIDTH. Results equal {cout,sum} = a + b + cin (add) or a + ~b + 1 (subtract).
- Reset asserted in any state, including mid-RUN, takes priority over start and all other activity. It applies the reset values on that edge, and any in-flight operation is discarded.

## Timing

- Start accepted at edge 0: busy=1 from after edge 0 until edge WIDTH, which is WIDTH cycles.
- done=1 from after edge WIDTH until edge WIDTH+1, with sum, cout and overflow valid from the same point.
- Earliest next accepted start is at edge WIDTH+2, when the FSM is in IDLE. Throughput is one operation per WIDTH+2 cycles.
- busy and done are never high together, and both are registered outputs.
- Operand inputs may change freely after the start edge; only the values sampled with start are used.

## Test plan

- **Add with carry-out:** WIDTH=8, a=0xFF, b=0x01, cin=0, sub=0 → at done: sum=0x00, cout=1, overflow=0. done is high exactly one cycle, after edge 8; busy is high for 8 cycles.
- **Signed overflow and carry-in:**
  - a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, overflow=1.
  - a=0x10, b=0x20, cin=1 → sum=0x31, cout=0, overflow=0.
- **Subtract:**
  - sub=1, a=0x05, b=0x07, cin=1 (ignored) → sum=0xFE, cout=0, overflow=0.
  - sub=1, a=0x80, b=0x01 → sum=0x7F, cout=1, overflow=1.
- **Handshake robustness:**
  - Start with a=0x03, b=0x04.
  - During RUN, hold start=1 with a=0xAA, b=0x55 → result sum=0x07.
  - A start held through DONE is not accepted.
  - The next start in IDLE is accepted normally.
- **Reset mid-operation:**
  - Assert rst at edge 4 of a RUN → busy=0, done=0, sum=0, cout=0, overflow=0 on that edge, and no done pulse follows.
  - A new start afterwards (a=0x01, b=0x01) → sum=0x02.
- **Randomised sweep:**
  - WIDTH=4: all 512 combinations of a, b, cin in add mode, plus all 256 combinations of a, b in subtract mode.
  - For each, check sum, cout and overflow against a reference model, and check done latency = WIDTH cycles from start.
